// File: rtl/mem_port_arb_if.sv
// Bundle of the arbiter's request/response and memory-side signals.
//   slave  : arbiter view (takes fetch/data requests, drives memory side)
//   master : environment view (requesters + memory model)
interface mem_port_arb_if #(
  parameter int unsigned N = 16
);
  // fetch port
  logic         i_req;
  logic [N-1:0] i_addr;
  logic         i_done;
  logic [N-1:0] i_rdata;
  // data port
  logic         d_req;
  logic         d_wr;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic         d_done;
  logic [N-1:0] d_rdata;
  // memory side
  logic         mem_en;
  logic         mem_wr;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_done;
  // status
  logic         err;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr,
           mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr,
           mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arb.sv
// Two-port (fetch / data) arbiter in front of a single memory port.
// One transaction at a time, round-robin on contention, timeout with a
// sticky error flag.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arb_if.slave -- fetch/data request ports, memory
//           issue/response signals and err.
// i_done/d_done and i_rdata/d_rdata are combinational responses to
// mem_done (or the timeout) in the busy state; all memory-side outputs
// and err are registered.
module mem_port_arb #(
  parameter int unsigned N       = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_port_arb_if.slave bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          last_d_q, last_d_d;  // 1: last grant went to the data port
  logic          hit_to_c;
  logic          i_done_c, d_done_c;
  logic [N-1:0]  i_rdata_c, d_rdata_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      last_d_q <= last_d_d;
    end
  end

  // Next state, register updates and combinational completion
  always_comb begin
    state_d   = state_q;
    mem_en_d  = 1'b0;
    mem_wr_d  = mem_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    last_d_d  = last_d_q;
    i_done_c  = 1'b0;
    d_done_c  = 1'b0;
    i_rdata_c = '0;
    d_rdata_c = '0;
    hit_to_c  = (cnt_q == TO_VAL);

    case (state_q)
      IDLE: begin
        // data wins unless fetch is also waiting and data had the last turn
        if (bus.d_req && (!bus.i_req || !last_d_q)) begin
          mem_en_d = 1'b1;
          mem_wr_d = bus.d_wr;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          cnt_d    = '0;
          last_d_d = 1'b1;
          state_d  = BUSY_D;
        end else if (bus.i_req) begin
          mem_en_d = 1'b1;
          mem_wr_d = 1'b0;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          cnt_d    = '0;
          last_d_d = 1'b0;
          state_d  = BUSY_I;
        end
      end

      BUSY_I: begin
        // mem_done takes priority over a coincident timeout
        if (bus.mem_done) begin
          i_done_c  = 1'b1;
          i_rdata_c = bus.mem_rdata;
          state_d   = IDLE;
        end else if (hit_to_c) begin
          i_done_c = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      BUSY_D: begin
        if (bus.mem_done) begin
          d_done_c  = 1'b1;
          d_rdata_c = mem_wr_q ? '0 : bus.mem_rdata;
          state_d   = IDLE;
        end else if (hit_to_c) begin
          d_done_c = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err       = err_q;
  assign bus.i_done    = i_done_c;
  assign bus.i_rdata   = i_rdata_c;
  assign bus.d_done    = d_done_c;
  assign bus.d_rdata   = d_rdata_c;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: transaction-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arb;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mem_port_arb_if #(.N(16)) bus ();

  mem_port_arb #(.N(16), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: owner 0 = none, 1 = fetch, 2 = data; age = cycles since issue
  int          m_owner;
  int          m_age;
  logic        m_pref_d;   // data wins the next contention
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_err;
  logic        e_fin;
  int          g;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_pref_d = 1'b1;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_err = 1'b0;
    end
    e_fin = (m_owner != 0) && (bus.mem_done || m_age == TO);
    chk("model mem_en",    32'(bus.mem_en),    32'(m_owner != 0 && m_age == 0));
    chk("model mem_wr",    32'(bus.mem_wr),    32'(m_wr));
    chk("model mem_addr",  32'(bus.mem_addr),  32'(m_addr));
    chk("model mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    chk("model err",       32'(bus.err),       32'(m_err));
    chk("model i_done",    32'(bus.i_done),    32'(e_fin && m_owner == 1));
    chk("model d_done",    32'(bus.d_done),    32'(e_fin && m_owner == 2));
    chk("model i_rdata",   32'(bus.i_rdata),
        (m_owner == 1 && bus.mem_done) ? 32'(bus.mem_rdata) : 32'd0);
    chk("model d_rdata",   32'(bus.d_rdata),
        (m_owner == 2 && bus.mem_done && !m_wr) ? 32'(bus.mem_rdata) : 32'd0);
    if (rst_n) begin
      if (m_owner != 0) begin
        if (e_fin) begin
          if (!bus.mem_done) m_err = 1'b1;
          m_owner = 0;
        end else begin
          m_age++;
        end
      end else begin
        g = 0;
        if (bus.d_req && bus.i_req) g = m_pref_d ? 2 : 1;
        else if (bus.d_req)         g = 2;
        else if (bus.i_req)         g = 1;
        if (g == 2) begin
          m_wr = bus.d_wr; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
        end else if (g == 1) begin
          m_wr = 1'b0; m_addr = bus.i_addr; m_wdata = '0;
        end
        if (g != 0) begin
          m_owner = g; m_age = 0; m_pref_d = (g == 1);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 1'b0;
  endtask

  // Ends at posedge+1 of the first cycle out of reset
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns at posedge+2 of the cycle where mem_en is seen; n = cycles waited
  task automatic wait_issue(input string name, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      n++;
      if (bus.mem_en) break;
    end
    chk({name, " issue"}, 32'(bus.mem_en), 32'd1);
  endtask

  // mem_done `dly` cycles ahead, check the done outputs that cycle
  task automatic complete(input int dly, input logic [15:0] rd, input string name,
                          input logic ei, input logic ed, input logic [31:0] erd);
    repeat (dly) @(posedge clk);
    #1 bus.mem_done = 1'b1; bus.mem_rdata = rd;
    #1;
    chk({name, " i_done"}, 32'(bus.i_done), 32'(ei));
    chk({name, " d_done"}, 32'(bus.d_done), 32'(ed));
    chk({name, " rdata"},  ed ? 32'(bus.d_rdata) : 32'(bus.i_rdata), erd);
    @(posedge clk);
    #1 bus.mem_done = 1'b0; bus.mem_rdata = '0;
  endtask

  logic [15:0] ord_addr [4];
  logic        ord_d    [4];
  int          n;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    ord_addr = '{16'h0200, 16'h0100, 16'h0200, 16'h0100};
    ord_d    = '{1'b1, 1'b0, 1'b1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_en",   32'(bus.mem_en),   0);
    chk("rst mem_addr", 32'(bus.mem_addr), 0);
    chk("rst err",      32'(bus.err),      0);
    chk("rst d_done",   32'(bus.d_done),   0);
    rst_n = 1'b1;

    // single data read, memory answers 3 cycles after issue
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0040;
    wait_issue("rd", n);
    chk("rd latency",  32'(n), 1);
    chk("rd mem_addr", 32'(bus.mem_addr), 'h0040);
    chk("rd mem_wr",   32'(bus.mem_wr), 0);
    complete(3, 16'hBEEF, "rd", 1'b0, 1'b1, 'hBEEF);
    bus.d_req = 1'b0;

    // data write: strobe and data held, no read data returned
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h1234; bus.d_wdata = 16'h5A5A;
    wait_issue("wr", n);
    chk("wr latency",  32'(n), 1);
    chk("wr mem_wr",   32'(bus.mem_wr), 1);
    chk("wr mem_addr", 32'(bus.mem_addr), 'h1234);
    @(posedge clk); #2;
    chk("wr mem_en pulse", 32'(bus.mem_en), 0);
    chk("wr mem_wdata",    32'(bus.mem_wdata), 'h5A5A);
    complete(1, 16'hFFFF, "wr", 1'b0, 1'b1, 0);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;

    // contention from reset: D, I, D, I with one idle cycle between
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    bus.d_req = 1'b1; bus.d_addr = 16'h0200;
    for (int t = 0; t < 4; t++) begin
      wait_issue("rr", n);
      chk("rr gap", 32'(n), 1);
      chk("rr order", 32'(bus.mem_addr), 32'(ord_addr[t]));
      complete(1, 16'h1000 + 16'(t), "rr", !ord_d[t], ord_d[t], 32'h1000 + 32'(t));
    end

    // fetch with no memory response: timeout at cycle 15 after issue
    bus.d_req = 1'b0; bus.i_addr = 16'h0300; bus.mem_rdata = 16'hDEAD;
    wait_issue("to", n);
    chk("to mem_addr", 32'(bus.mem_addr), 'h0300);
    for (int t = 1; t <= TO; t++) begin
      @(posedge clk); #2;
      chk("to i_done", 32'(bus.i_done), 32'(t == TO));
    end
    chk("to i_rdata", 32'(bus.i_rdata), 0);
    @(posedge clk); #1 bus.i_req = 1'b0;
    #1 chk("to err set", 32'(bus.err), 1);
    @(posedge clk); #1 bus.mem_done = 1'b1; bus.mem_rdata = 16'hAAAA;
    #1 chk("late i_done", 32'(bus.i_done), 0);
    chk("late d_done", 32'(bus.d_done), 0);
    @(posedge clk); #1 bus.mem_done = 1'b0;
    #1 chk("late mem_en", 32'(bus.mem_en), 0);
    chk("err sticky", 32'(bus.err), 1);

    // mem_done exactly on the timeout cycle completes normally
    do_reset();
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0500;
    wait_issue("edge", n);
    repeat (TO - 1) @(posedge clk);
    complete(1, 16'h1357, "edge", 1'b0, 1'b1, 'h1357);
    bus.d_req = 1'b0;
    #1 chk("edge err", 32'(bus.err), 0);
    @(posedge clk); #2 chk("edge err later", 32'(bus.err), 0);

    // reset in the middle of a data transaction
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0600; bus.d_wdata = 16'h0F0F;
    wait_issue("mid", n);
    #1 rst_n = 1'b0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    #1;
    chk("mid mem_en",    32'(bus.mem_en), 0);
    chk("mid mem_wr",    32'(bus.mem_wr), 0);
    chk("mid mem_addr",  32'(bus.mem_addr), 0);
    chk("mid mem_wdata", 32'(bus.mem_wdata), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
    #1 chk("mid d_done", 32'(bus.d_done), 0);
    chk("mid i_done", 32'(bus.i_done), 0);
    @(posedge clk); #1 bus.mem_done = 1'b0;
    #1 chk("mid idle", 32'(bus.mem_en), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
